// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches level/edge sources, masks them and
// presents a registered HWInt vector plus PEND/MASK/MODE/ID registers to the Bridge.
module int_ctrl #(
  parameter int          N_SRC     = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
  parameter logic [5:0]  MODE_RST  = 6'b000100,
  parameter logic [5:0]  MASK_RST  = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [3:0]       byteen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] irq_src,
  output logic [5:0]       hwint,
  output logic             irq_any
);

  localparam logic [1:0] OFS_PEND = 2'd0;
  localparam logic [1:0] OFS_MASK = 2'd1;
  localparam logic [1:0] OFS_MODE = 2'd2;
  localparam logic [1:0] OFS_ID   = 2'd3;

  logic [N_SRC-1:0] r_src_d;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [5:0]       r_hwint;
  logic             r_irq_any;

  logic             w_in_win;
  logic             w_wr_en;
  logic             w_wr_pend;
  logic             w_wr_mask;
  logic             w_wr_mode;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_act;
  logic [2:0]       w_id;
  logic             w_unused;

  // 1 + index of the lowest set bit, 0 when nothing is set.
  function automatic logic [2:0] f_first_id(input logic [N_SRC-1:0] v);
    logic [2:0] id;
    id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        id = 3'(i + 1);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  assign w_in_win  = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr_en   = w_in_win && (byteen == 4'hF);
  assign w_wr_pend = w_wr_en && (addr[3:2] == OFS_PEND);
  assign w_wr_mask = w_wr_en && (addr[3:2] == OFS_MASK);
  assign w_wr_mode = w_wr_en && (addr[3:2] == OFS_MODE);
  assign w_rise    = irq_src & ~r_src_d;
  assign w_clr     = w_wr_pend ? wdata[N_SRC-1:0] : {N_SRC{1'b0}};
  assign w_act     = r_pend & r_mask;
  assign w_id      = f_first_id(w_act);
  assign w_unused  = ^{addr[1:0], wdata[31:N_SRC]};

  // Edge sources: a rising edge outranks a W1C landing in the same cycle.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_mode[i]) begin
        w_pend_nxt[i] = (r_pend[i] & ~w_clr[i]) | w_rise[i];
      end else begin
        w_pend_nxt[i] = irq_src[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src_d <= {N_SRC{1'b0}};
      r_pend  <= {N_SRC{1'b0}};
    end else begin
      r_src_d <= irq_src;
      r_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= MASK_RST[N_SRC-1:0];
      r_mode <= MODE_RST[N_SRC-1:0];
    end else begin
      if (w_wr_mask) begin
        r_mask <= wdata[N_SRC-1:0];
      end else begin
        r_mask <= r_mask;
      end
      if (w_wr_mode) begin
        r_mode <= wdata[N_SRC-1:0];
      end else begin
        r_mode <= r_mode;
      end
    end
  end

  // Outputs follow the registered PEND/MASK, so register writes act one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hwint   <= 6'b000000;
      r_irq_any <= 1'b0;
    end else begin
      r_hwint   <= 6'(w_act);
      r_irq_any <= |w_act;
    end
  end

  always_comb begin
    rdata = 32'h0000_0000;
    if (w_in_win) begin
      case (addr[3:2])
        OFS_PEND: rdata = 32'(r_pend);
        OFS_MASK: rdata = 32'(r_mask);
        OFS_MODE: rdata = 32'(r_mode);
        OFS_ID:   rdata = 32'(w_id);
        default:  rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  assign hwint   = r_hwint;
  assign irq_any = r_irq_any;

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller between the interrupt sources (TC0 IRQ, TC1 IRQ, the external `interrupt` pin) and the CPU's `HWInt` input. Each source is latched as either level or rising-edge, individually masked, and presented as a registered `HWInt` vector to CP0. Software reads and acknowledges pending interrupts through four word registers on the Bridge, in the device window directly after TC1.

## Interface
- `N_SRC`, 3: number of interrupt sources, 1..6; source i drives `hwint[i]`.
- `BASE_ADDR`, 32'h0000_7F20: byte base address of the 16-byte register window.
- `MODE_RST`, 3'b100: reset value of MODE. External pin defaults to edge; timers default to level.
- `MASK_RST`, all ones: reset value of MASK.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; all registers are cleared or preset while low.
- `addr`  in  32  byte address from the Bridge (`m_data_addr`).
- `byteen`  in  4  write byte enables, already gated to this device by the Bridge.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr`.
- `irq_src`  in  N_SRC  raw source lines: {interrupt, TC1_IRQ, TC0_IRQ} for N_SRC=3.
- `hwint`  out  6  registered interrupt vector to CP0; bits at or above N_SRC are tied to 0.
- `irq_any`  out  1  registered; equals `|hwint`.

## Operation
Register map. Offsets are taken from `BASE_ADDR` and decoded on `addr[3:2]`. `addr[1:0]` is ignored.
- `+0x0` PEND: read returns pending bits. A write clears every bit written as 1 (write-1-to-clear); bits written as 0 are unchanged.
- `+0x4` MASK: read/write. Bit i = 1 enables source i.
- `+0x8` MODE: read/write. Bit i = 1 selects edge mode; 0 selects level mode.
- `+0xC` ID: read-only. Returns 1 + index of the lowest-numbered bit of PEND&MASK, or 0 if none is set. Writes are ignored.

Write rules:
- A write takes effect only when `byteen == 4'hF` and `addr` lies in the window. Partial-byte writes are ignored entirely.
- Register bits at or above N_SRC read as 0 and ignore writes.
- `rdata` is 0 when `addr` is outside the window.

Source handling. `src_d` is a one-cycle delayed copy of `irq_src`, reset to 0.
- Edge mode: PEND[i] is set when `irq_src[i] & ~src_d[i]` is seen at a clock edge. It stays set until software clears it.
- Level mode: PEND[i] is loaded with `irq_src[i]` every cycle, so W1C has no lasting effect.
- If an edge set and a W1C of the same bit occur in the same cycle, the set wins and PEND stays 1.
- MODE change (level to edge): PEND keeps its current value. Only new rising edges set it afterwards.
- Masked sources still pend. Unmasking a pending source raises `hwint` on the next edge.

Output:
- `hwint[i] <= PEND[i] & MASK[i]` for i < N_SRC.
- `irq_any <= |(PEND & MASK)`.

## Timing
Reset values (reset low, asynchronous):
- PEND = 0, MASK = `MASK_RST`, MODE = `MODE_RST`, `src_d` = 0, `hwint` = 0, `irq_any` = 0.

Reset release:
- A source already high at reset release counts as one rising edge on the first clock, because `src_d` resets to 0.

Latency:
- A source high at clock edge t sets PEND at edge t; `hwint` is high at edge t+1.
- A one-cycle pulse on the external pin is captured in edge mode and never lost.

Register access:
- A write at edge t is visible on `rdata` and acts on `hwint` from edge t+1.
- Example: W1C at edge t drops `hwint` at t+1, unless the source re-pends in the same cycle.

Reset mid-operation:
- Asserting `reset` drops `hwint`/`irq_any` immediately, without waiting for a clock edge.
- All pending interrupts are discarded.

## Test plan
- Reset and default routing:
  - Hold reset low; check `hwint`=0 and MASK reads 0x7.
  - Release, then pulse `irq_src[2]` high for one cycle.
  - Required: PEND reads 0x4 and `hwint`=6'b000100 one cycle later, held until a W1C of 0x4 to 0x7F20. `hwint` reads 0 on the cycle after that write.
- Level timer:
  - Hold `irq_src[0]` high; write PEND=0x1.
  - Required: PEND stays 0x1. After `irq_src[0]` is deasserted, PEND=0 and `hwint[0]`=0 within 2 cycles.
- Mask and ID:
  - Set MASK=0x2, then pend sources 0 and 1 (edge mode).
  - Required: `hwint`=6'b000010 and ID reads 2. After writing MASK=0x3, `hwint`=6'b000011 and ID reads 1.
- Simultaneous set and clear:
  - In edge mode, produce a rising edge on source 2 in the same cycle as a W1C 0x4.
  - Required: PEND[2] remains 1.
- Partial write and out-of-window access:
  - Write MASK with `byteen`=4'b0011 and data 0.
  - Required: MASK unchanged at 0x7. A read from 0x7F30 returns 0.
- Async reset mid-interrupt:
  - With `hwint`=6'b000001, pull `reset` low between clock edges.
  - Required: `hwint` and `irq_any` go to 0 before the next edge, and PEND reads 0 after release.
